// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit: multi-cycle serial adder. It computes a + b + ci over WIDTH bits,
// handling DIGIT bits per clock in a DIGIT-wide ripple slice with a registered carry.
// A run takes N = WIDTH/DIGIT clocks from the accepted start edge to the done pulse.
//
// Ports:
//   clk   - clock; all state updates on the rising edge
//   rst   - synchronous reset, active-high; aborts any run in progress
//   start - request; sampled only when idle or done
//   a, b  - WIDTH-bit operands, captured when start is accepted
//   ci    - carry-in, captured when start is accepted
//   sub   - (only with SERIAL_ADDER_SUB_EN) 1 = compute a - b - ci
//   busy  - high while a run is in progress
//   done  - one-cycle pulse when s/co/ov take a new result
//   s     - registered sum, held until the next completed run
//   co    - carry-out of bit WIDTH-1 (for subtract: 1 = no borrow)
//   ov    - signed overflow (carry into MSB xor carry-out)
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input.

module serial_adder_nbit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic             sub_w;
  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic             last_step;
  logic             rc;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  // Ripple slice over the low DIGIT bits of the operand shift registers.
  always_comb begin
    rc         = carry_q;
    slice_sum  = '0;
    slice_cmsb = 1'b0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      slice_sum[i] = a_sh_q[i] ^ b_sh_q[i] ^ rc;
      slice_cmsb   = rc;  // after the loop: carry into the slice MSB
      rc           = (a_sh_q[i] & b_sh_q[i]) | (rc & (a_sh_q[i] ^ b_sh_q[i]));
    end
    slice_cout = rc;
  end

  assign last_step = (cnt_q == CntW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    ov_d    = ov_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_sh_d  = a;
          // Subtract as a + ~b + ~ci, which equals a - b - ci mod 2^WIDTH.
          b_sh_d  = sub_w ? ~b : b;
          carry_d = ci ^ sub_w;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        // New sum digits enter at the MSB end so the LSB digit lands at bit 0.
        res_d   = (res_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
        carry_d = slice_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (last_step) begin
          state_d = StDone;
          s_d     = res_d;
          co_d    = slice_cout;
          ov_d    = slice_cmsb ^ slice_cout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign s    = s_q;
  assign co   = co_q;
  assign ov   = ov_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit: an 8-bit/1-digit instance checked every cycle against an
// arithmetic reference model, plus a 16-bit/4-digit instance with directed checks.

module tb_serial_adder_nbit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       ci;
  logic       sub_r;
  logic       busy, done, co, ov;
  logic [7:0] s;

  logic        start16;
  logic [15:0] a16, b16;
  logic        ci16;
  logic        busy16, done16, co16, ov16;
  logic [15:0] s16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .ci   (ci),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub_r),
`endif
    .busy (busy),
    .done (done),
    .s    (s),
    .co   (co),
    .ov   (ov)
  );

  serial_adder_nbit #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk  (clk),
    .rst  (rst),
    .start(start16),
    .a    (a16),
    .b    (b16),
    .ci   (ci16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (1'b0),
`endif
    .busy (busy16),
    .done (done16),
    .s    (s16),
    .co   (co16),
    .ov   (ov16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {ov, co, s} from plain integer arithmetic.
  function automatic logic [9:0] ref_result(input logic [7:0] x, input logic [7:0] y,
                                            input logic c, input logic sb);
    int ux, uy, sx, sy, ur, sr, cc;
    logic rco, rov;
    logic [7:0] rs;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    cc = c;
    if (sb) begin
      ur  = ux - uy - cc;
      sr  = sx - sy - cc;
      rco = (ux >= uy + cc);
    end else begin
      ur  = ux + uy + cc;
      sr  = sx + sy + cc;
      rco = (ur > 255);
    end
    rs  = ur[7:0];
    rov = (sr > 127) || (sr < -128);
    return {rov, rco, rs};
  endfunction

  // Transaction-level model of the 8-bit instance: accept when not busy, finish 8 edges later.
  logic       m_valid = 1'b0;
  logic       m_busy, m_done, m_co, m_ov;
  logic [7:0] m_s;
  logic [9:0] m_pend;
  int         m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_s     <= '0;
      m_co    <= 1'b0;
      m_ov    <= 1'b0;
      m_left  <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_left <= 8;
          m_pend <= ref_result(a, b, ci, sub_r);
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_left <= 0;
        {m_ov, m_co, m_s} <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(done), 32'(m_done));
      check("model_s",    32'(s),    32'(m_s));
      check("model_co",   32'(co),   32'(m_co));
      check("model_ov",   32'(ov),   32'(m_ov));
    end
  end

  // Waits for done; lat = number of edges after the start edge.
  task automatic wait_done(output int lat);
    bit found = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat   = i;
        found = 1'b1;
        break;
      end
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Starts an 8-bit op from the current time and waits for its done pulse.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, output int lat);
    a     = x;
    b     = y;
    ci    = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done(lat);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  logic [9:0] vec_in [3];
  logic [9:0] vec_exp [3];

  initial begin
    int lat, nd;
    bit found;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub_r = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s",    32'(s),    32'h00);
    check("rst_co",   32'(co),   32'd0);
    check("rst_ov",   32'(ov),   32'd0);
    rst = 1'b0;

    // 35 + 4A: s must still read 00 right after start.
    @(negedge clk);
    a = 8'h35; b = 8'h4A; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t2_s_hold", 32'(s), 32'h00);
    wait_done(lat);
    check("t2_latency", 32'(lat), 32'd8);
    check("t2_s",  32'(s),  32'h7F);
    check("t2_co", 32'(co), 32'd0);
    check("t2_ov", 32'(ov), 32'd0);

    // FF + 01, then back-to-back 7F + 01 started while done is high.
    @(negedge clk);
    op8(8'hFF, 8'h01, 1'b0, lat);
    check("t3a_s",  32'(s),  32'h00);
    check("t3a_co", 32'(co), 32'd1);
    check("t3a_ov", 32'(ov), 32'd0);
    op8(8'h7F, 8'h01, 1'b0, lat);
    check("t3b_latency", 32'(lat), 32'd8);
    check("t3b_s",  32'(s),  32'h80);
    check("t3b_co", 32'(co), 32'd0);
    check("t3b_ov", 32'(ov), 32'd1);

    // Start during a run is ignored.
    repeat (2) @(negedge clk);
    a = 8'h10; b = 8'h20; ci = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 8'hAA; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 8'h00;
    wait_done(lat);
    check("t4_s", 32'(s), 32'h30);
    count_dones(12, nd);
    check("t4_single_done", 32'(nd), 32'd0);

    // Reset mid-run aborts with no done.
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_s",    32'(s),    32'h00);
    check("t5_done", 32'(done), 32'd0);
    count_dones(14, nd);
    check("t5_no_done", 32'(nd), 32'd0);

    // Extra vectors with carry-in: {ci, b} packed in, {ov, co, s} expected; a fixed per row.
    vec_in[0] = {1'b1, 1'b0, 8'h80}; vec_exp[0] = {1'b1, 1'b1, 8'h01};
    vec_in[1] = {1'b1, 1'b0, 8'h40}; vec_exp[1] = {1'b0, 1'b1, 8'h01};
    vec_in[2] = {1'b1, 1'b0, 8'h7F}; vec_exp[2] = {1'b1, 1'b0, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      logic [7:0] av;
      av = (i == 0) ? 8'h80 : (i == 1) ? 8'hC0 : 8'h7F;
      @(negedge clk);
      op8(av, vec_in[i][7:0], vec_in[i][9], lat);
      check("vec_result", 32'({ov, co, s}), 32'(vec_exp[i]));
    end

    // 16-bit, 4 bits per clock.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a16 = (i == 0) ? 16'hFFFF : 16'h7FFF;
      b16 = (i == 0) ? 16'h0000 : 16'h0001;
      ci16 = (i == 0);
      start16 = 1'b1;
      @(posedge clk);
      #1;
      start16 = 1'b0;
      found = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done16) begin
          lat = k;
          found = 1'b1;
          break;
        end
      end
      if (!found) check("w16_timeout", 32'd0, 32'd1);
      check("w16_latency", 32'(lat), 32'd4);
      check("w16_s",  32'(s16),  (i == 0) ? 32'h0000 : 32'h8000);
      check("w16_co", 32'(co16), (i == 0) ? 32'd1 : 32'd0);
      check("w16_ov", 32'(ov16), (i == 0) ? 32'd0 : 32'd1);
    end

`ifdef SERIAL_ADDER_SUB_EN
    // 05 - 07 - 0 = FE with a borrow.
    @(negedge clk);
    sub_r = 1'b1;
    op8(8'h05, 8'h07, 1'b0, lat);
    sub_r = 1'b0;
    check("sub_s",  32'(s),  32'hFE);
    check("sub_co", 32'(co), 32'd0);
    check("sub_ov", 32'(ov), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
